// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout set when the bit underflows.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow out for a single bit position.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor. Accepts an operand pair in IDLE, processes
// one bit per cycle LSB first in SHIFT, and presents {borrow_out, diff} in
// DONE until the consumer takes it.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid never depends on ready, and a presented result stays stable
// until it is taken.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output state_e           state_dbg
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   diff_sh_q, diff_sh_d;  // result under construction
  logic [WIDTH-1:0]   diff_q, diff_d;        // last completed result
  logic               borrow_out_q, borrow_out_d;
  logic               br_q, br_d;            // running borrow between bits
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic fs_d;
  logic fs_bout;
  logic last_bit;

  full_subtractor u_fs (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (br_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  // FSM state register; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: accept in IDLE, run WIDTH bit steps, wait for the consumer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = SHIFT;
      SHIFT:   if (last_bit)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // FSM outputs: ready only while idle, valid only while a result is held.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    state_dbg = state_q;
  end

  // Datapath next-state: load on accept, shift one bit per SHIFT cycle, and
  // publish the result only on the final bit so diff never shows a partial value.
  always_comb begin
    a_d          = a_q;
    b_d          = b_q;
    diff_sh_d    = diff_sh_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
    br_d         = br_q;
    cnt_d        = cnt_q;
    if (state_q == IDLE && in_valid) begin
      a_d   = operand_a;
      b_d   = operand_b;
      br_d  = 1'b0;
      cnt_d = '0;
    end else if (state_q == SHIFT) begin
      a_d       = a_q >> 1;
      b_d       = b_q >> 1;
      br_d      = fs_bout;
      cnt_d     = cnt_q + CNT_W'(1);
      diff_sh_d = {fs_d, diff_sh_q[WIDTH-1:1]};
      if (last_bit) begin
        diff_d       = {fs_d, diff_sh_q[WIDTH-1:1]};
        borrow_out_d = fs_bout;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q          <= '0;
      b_q          <= '0;
      diff_sh_q    <= '0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      br_q         <= 1'b0;
      cnt_q        <= '0;
    end else begin
      a_q          <= a_d;
      b_q          <= b_d;
      diff_sh_q    <= diff_sh_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
      br_q         <= br_d;
      cnt_q        <= cnt_d;
    end
  end

  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH = 4).
module tb_serial_subtractor;
  import serial_sub_pkg::*;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  state_e           state_dbg;

  int checks = 0;
  int errors = 0;
  logic [WIDTH:0] exp_q[$];

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out),
    .state_dbg  (state_dbg)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver: one full operation starting at a negedge in IDLE. Optionally holds
  // the result with out_ready low for 'hold' cycles while disturbing inputs.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] ed, input logic eb,
                        input int hold, input string tag);
    int k;
    operand_a = a;
    operand_b = b;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    in_valid  = 1'b0;
    operand_a = ~a;
    operand_b = ~b;
    check({tag, ".busy"}, 32'(in_ready), 32'd0);
    k = 0;
    while (!out_valid && k < 3 * WIDTH) begin
      @(posedge clk); @(negedge clk);
      k++;
    end
    check({tag, ".latency"}, 32'(k), 32'(WIDTH));
    if (!out_valid) return;
    check({tag, ".diff"}, 32'(diff), 32'(ed));
    check({tag, ".borrow"}, 32'(borrow_out), 32'(eb));
    for (int h = 0; h < hold; h++) begin
      in_valid  = 1'b1;
      operand_a = a + WIDTH'(h + 1);
      operand_b = b ^ WIDTH'(h + 3);
      @(posedge clk); @(negedge clk);
      check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, ".hold_ready"}, 32'(in_ready), 32'd0);
      check({tag, ".hold_diff"}, 32'(diff), 32'(ed));
      check({tag, ".hold_borrow"}, 32'(borrow_out), 32'(eb));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".post_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".post_ready"}, 32'(in_ready), 32'd1);
    check({tag, ".post_diff"}, 32'(diff), 32'(ed));
  endtask

  // Back-to-back stream: in_valid and out_ready held high; the scoreboard
  // checks ordering and the accept spacing.
  task automatic run_stream();
    logic [WIDTH-1:0] va [4];
    logic [WIDTH-1:0] vb [4];
    logic [WIDTH:0]   ve [4];
    logic [WIDTH:0]   e;
    int idx, results, last_acc;
    logic acc_now;
    va[0] = 4'd7;  vb[0] = 4'd2;  ve[0] = 5'b0_0101;
    va[1] = 4'd2;  vb[1] = 4'd7;  ve[1] = 5'b1_1011;
    va[2] = 4'd8;  vb[2] = 4'd8;  ve[2] = 5'b0_0000;
    va[3] = 4'd15; vb[3] = 4'd0;  ve[3] = 5'b0_1111;
    idx = 0; results = 0; last_acc = -1;
    operand_a = va[0];
    operand_b = vb[0];
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 80 && results < 4; cyc++) begin
      acc_now = 1'b0;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("b2b.unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("b2b.diff", 32'(diff), 32'(e[WIDTH-1:0]));
          check("b2b.borrow", 32'(borrow_out), 32'(e[WIDTH]));
        end
        results++;
      end
      if (in_ready && idx < 4) begin
        exp_q.push_back(ve[idx]);
        if (last_acc >= 0) check("b2b.spacing", 32'(cyc - last_acc), 32'(WIDTH + 2));
        last_acc = cyc;
        acc_now  = 1'b1;
      end
      @(posedge clk); @(negedge clk);
      if (acc_now) begin
        idx++;
        if (idx < 4) begin
          operand_a = va[idx];
          operand_b = vb[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b.results", 32'(results), 32'd4);
    check("b2b.queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    operand_a = '0;
    operand_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.diff", 32'(diff), 32'd0);
    check("rst.borrow", 32'(borrow_out), 32'd0);
    check("rst.state", 32'(state_dbg), 32'(IDLE));
    rst = 1'b0;

    // First pair accepted on the first edge after reset release.
    run_op(4'b1101, 4'b0011, 4'b1010, 1'b0, 0, "a13_b3");
    run_op(4'b0011, 4'b1101, 4'b0110, 1'b1, 0, "a3_b13");
    run_op(4'd0,    4'd1,    4'b1111, 1'b1, 0, "a0_b1");
    run_op(4'd15,   4'd15,   4'b0000, 1'b0, 0, "a15_b15");
    run_op(4'd12,   4'd5,    4'b0111, 1'b0, 5, "bp_a12_b5");

    run_stream();

    // Reset two bits into an operation.
    operand_a = 4'd6;
    operand_b = 4'd1;
    in_valid  = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst.out_valid", 32'(out_valid), 32'd0);
    check("midrst.diff", 32'(diff), 32'd0);
    check("midrst.borrow", 32'(borrow_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("midrst.in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); @(negedge clk);
      check("midrst.idle_valid", 32'(out_valid), 32'd0);
    end
    run_op(4'd9, 4'd4, 4'b0101, 1'b0, 0, "a9_b4");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
